// File: rtl/rmii_tx_framer.sv
// RMII 100 Mb/s transmit framer: turns a byte stream into TXD dibits with preamble,
// SFD, zero padding, CRC-32 FCS and inter-packet gap.
//
// state    | meaning
// IDLE     | line quiet, waiting for tx_valid
// PREAMBLE | sending 0x55 bytes
// SFD      | sending 0xD5, first byte requested on its last dibit
// DATA     | sending payload bytes from tx_data
// PAD      | sending 0x00 bytes up to the minimum frame length
// FCS      | sending ~CRC, low byte first
// IPG      | TXEN low for the inter-packet gap
module rmii_tx_framer #(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int MIN_FRAME_BYTES = 60,
   parameter int IPG_BYTES       = 12
) (
   input  logic       eth_clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [1:0] ETH_TXD,
   output logic       ETH_TXEN,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int IPG_CYC = IPG_BYTES * 4;
   localparam int IPG_W   = (IPG_CYC > 1) ? $clog2(IPG_CYC) : 1;
   localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_CYC - 1);
   localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_BYTES - 1);
   localparam logic [10:0]      MIN_CNT  = 11'(MIN_FRAME_BYTES);

   typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG} state_t;

   state_t           state;
   logic [1:0]       dibit_cnt;
   logic [5:0]       sh;
   logic             cur_last;
   logic [31:0]      crc;
   logic [10:0]      byte_cnt;
   logic [7:0]       idx_cnt;
   logic [IPG_W-1:0] ipg_cnt;

   logic [31:0] crc_inv, crc_dat, crc_pad;
   logic [7:0]  fcs_nxt;
   logic [10:0] byte_cnt_inc;
   logic        want_byte, pad_or_fcs;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      crc_inv      = ~crc;
      crc_dat      = crc_byte(crc, tx_data);
      crc_pad      = crc_byte(crc, 8'h00);
      byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
      want_byte    = (state == SFD) || (state == DATA && !cur_last);
      pad_or_fcs   = (state == DATA && cur_last) || (state == PAD);
      case (idx_cnt[1:0])
         2'd0:    fcs_nxt = crc_inv[15:8];
         2'd1:    fcs_nxt = crc_inv[23:16];
         2'd2:    fcs_nxt = crc_inv[31:24];
         default: fcs_nxt = crc_inv[7:0];
      endcase
   end

   // state/dibit_cnt/sh always describe the dibit currently on the wire
   always_ff @(posedge eth_clk) begin
      if (rst) begin
         state      <= IDLE;
         dibit_cnt  <= 2'd0;
         sh         <= 6'd0;
         cur_last   <= 1'b0;
         crc        <= 32'hFFFFFFFF;
         byte_cnt   <= 11'd0;
         idx_cnt    <= 8'd0;
         ipg_cnt    <= '0;
         tx_ready   <= 1'b0;
         ETH_TXD    <= 2'b00;
         ETH_TXEN   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         tx_ready   <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  state     <= PREAMBLE;
                  busy      <= 1'b1;
                  ETH_TXEN  <= 1'b1;
                  ETH_TXD   <= 2'b01;
                  sh        <= 6'b010101;
                  dibit_cnt <= 2'd0;
                  idx_cnt   <= 8'd0;
               end
            end
            IPG: begin
               if (ipg_cnt == '0) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  crc      <= 32'hFFFFFFFF;
                  byte_cnt <= 11'd0;
               end else begin
                  ipg_cnt <= ipg_cnt - 1'b1;
               end
            end
            default: begin
               if (dibit_cnt != 2'd3) begin
                  dibit_cnt <= dibit_cnt + 2'd1;
                  ETH_TXD   <= sh[1:0];
                  sh        <= {2'b00, sh[5:2]};
                  if (dibit_cnt == 2'd2 && want_byte)
                     tx_ready <= 1'b1;
                  if (dibit_cnt == 2'd2 && state == FCS && idx_cnt == 8'd3)
                     frame_done <= 1'b1;
               end else begin
                  dibit_cnt <= 2'd0;
                  if (state == PREAMBLE) begin
                     ETH_TXD <= 2'b01;
                     if (idx_cnt == PRE_LAST) begin
                        state <= SFD;
                        sh    <= 6'b110101;
                     end else begin
                        idx_cnt <= idx_cnt + 8'd1;
                        sh      <= 6'b010101;
                     end
                  end else if (want_byte) begin
                     if (tx_valid) begin
                        state    <= DATA;
                        ETH_TXD  <= tx_data[1:0];
                        sh       <= tx_data[7:2];
                        cur_last <= tx_last;
                        crc      <= crc_dat;
                        byte_cnt <= byte_cnt_inc;
                     end else begin
                        state    <= IPG;
                        ETH_TXEN <= 1'b0;
                        ETH_TXD  <= 2'b00;
                        underrun <= 1'b1;
                        ipg_cnt  <= IPG_LAST;
                     end
                  end else if (pad_or_fcs) begin
                     if (byte_cnt < MIN_CNT) begin
                        state    <= PAD;
                        ETH_TXD  <= 2'b00;
                        sh       <= 6'd0;
                        crc      <= crc_pad;
                        byte_cnt <= byte_cnt_inc;
                     end else begin
                        state   <= FCS;
                        idx_cnt <= 8'd0;
                        ETH_TXD <= crc_inv[1:0];
                        sh      <= crc_inv[7:2];
                     end
                  end else begin
                     if (idx_cnt == 8'd3) begin
                        state    <= IPG;
                        ETH_TXEN <= 1'b0;
                        ETH_TXD  <= 2'b00;
                        ipg_cnt  <= IPG_LAST;
                     end else begin
                        idx_cnt <= idx_cnt + 8'd1;
                        ETH_TXD <= fcs_nxt[1:0];
                        sh      <= fcs_nxt[7:2];
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule
